// File: rtl/decode_exec_ctrl_if.sv
// Decode-stage bus: instruction/operands in, branch resolution and ID/EX bundle out.
// Handshake semantics: there is no valid/ready pair on this bus. The upstream side
// presents a new instruction every cycle. i_stall holds the ID/EX bundle, and i_kill
// replaces it with a bubble. The branch outputs are combinational and valid in the
// same cycle as the instruction.
interface decode_exec_ctrl_if;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_prediction;
    logic        i_stall;
    logic        i_kill;
    logic        o_boj;
    logic [31:0] o_branch_pc;
    logic        o_flush;
    logic [31:0] o_imm;
    logic [3:0]  o_alu_ctrl;
    logic [6:0]  o_opcode;
    logic [2:0]  o_func3;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_pc;

    // Upstream (fetch / register file / control) side.
    modport master (
        output i_instr, i_pc, i_rs1_data, i_rs2_data, i_prediction, i_stall, i_kill,
        input  o_boj, o_branch_pc, o_flush, o_imm, o_alu_ctrl, o_opcode, o_func3,
               o_rs1_data, o_rs2_data, o_pc
    );

    // Decode block side.
    modport slave (
        input  i_instr, i_pc, i_rs1_data, i_rs2_data, i_prediction, i_stall, i_kill,
        output o_boj, o_branch_pc, o_flush, o_imm, o_alu_ctrl, o_opcode, o_func3,
               o_rs1_data, o_rs2_data, o_pc
    );
endinterface

// File: rtl/decode_exec_ctrl.sv
// RV32I decode stage: immediate generation, ALU-control encoding, branch/jump
// resolution (combinational, for IF) and the registered ID/EX bundle.
module decode_exec_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic             clk,
    input logic             rst_n,
    decode_exec_ctrl_if.slave bus
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Sign-extended immediate for any instruction; unknown opcodes and R-type give 0.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (instr[6:0])
            OP_I, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_S:                   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_B:                   imm = {{19{instr[31]}}, instr[31], instr[7],
                                           instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:       imm = {instr[31:12], 12'b0};
            OP_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                           instr[20], instr[30:21], 1'b0};
            default:                imm = '0;
        endcase
        return imm;
    endfunction

    // ALU operation code; everything without its own encoding is ADD.
    function automatic logic [3:0] gen_alu(input logic [31:0] instr);
        logic [3:0] alu;
        alu = 4'b0000;
        case (instr[6:0])
            OP_R:    alu = {instr[30], instr[14:12]};
            // Only the shift-right group uses bit 30 (SRLI vs SRAI); ADDI with a
            // negative immediate must not turn into SUB.
            OP_I:    alu = {(instr[14:12] == 3'b101) ? instr[30] : 1'b0, instr[14:12]};
            OP_B:    alu = 4'b1000;
            default: alu = 4'b0000;
        endcase
        return alu;
    endfunction

    logic [31:0] imm;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic        cond;

    assign imm         = gen_imm(bus.i_instr);
    assign pc_plus_imm = bus.i_pc + imm;
    assign jalr_sum    = bus.i_rs1_data + imm;

    // Branch condition from func3; reserved encodings 010/011 never take.
    always_comb begin
        cond = 1'b0;
        case (bus.i_instr[14:12])
            3'b000:  cond = (bus.i_rs1_data == bus.i_rs2_data);
            3'b001:  cond = (bus.i_rs1_data != bus.i_rs2_data);
            3'b100:  cond = ($signed(bus.i_rs1_data) <  $signed(bus.i_rs2_data));
            3'b101:  cond = ($signed(bus.i_rs1_data) >= $signed(bus.i_rs2_data));
            3'b110:  cond = (bus.i_rs1_data <  bus.i_rs2_data);
            3'b111:  cond = (bus.i_rs1_data >= bus.i_rs2_data);
            default: cond = 1'b0;
        endcase
    end

    // Redirect decision and target for IF; the not-taken target is the fall-through PC.
    always_comb begin
        bus.o_boj       = 1'b0;
        bus.o_branch_pc = bus.i_pc + 32'd4;
        case (bus.i_instr[6:0])
            OP_B: begin
                bus.o_boj       = cond;
                bus.o_branch_pc = cond ? pc_plus_imm : bus.i_pc + 32'd4;
            end
            OP_JAL: begin
                bus.o_boj       = 1'b1;
                bus.o_branch_pc = pc_plus_imm;
            end
            OP_JALR: begin
                bus.o_boj       = 1'b1;
                bus.o_branch_pc = {jalr_sum[31:1], 1'b0};
            end
            default: begin
                bus.o_boj       = 1'b0;
                bus.o_branch_pc = bus.i_pc + 32'd4;
            end
        endcase
    end

    assign bus.o_flush = bus.i_prediction ^ bus.o_boj;

    // ID/EX register: kill beats stall; a kill keeps the PC so the bubble stays traceable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_imm      <= '0;
            bus.o_alu_ctrl <= '0;
            bus.o_opcode   <= OP_I;
            bus.o_func3    <= '0;
            bus.o_rs1_data <= '0;
            bus.o_rs2_data <= '0;
            bus.o_pc       <= '0;
        end else if (bus.i_kill) begin
            bus.o_imm      <= gen_imm(NOP_INSTR);
            bus.o_alu_ctrl <= gen_alu(NOP_INSTR);
            bus.o_opcode   <= NOP_INSTR[6:0];
            bus.o_func3    <= NOP_INSTR[14:12];
            bus.o_rs1_data <= '0;
            bus.o_rs2_data <= '0;
        end else if (!bus.i_stall) begin
            bus.o_imm      <= imm;
            bus.o_alu_ctrl <= gen_alu(bus.i_instr);
            bus.o_opcode   <= bus.i_instr[6:0];
            bus.o_func3    <= bus.i_instr[14:12];
            bus.o_rs1_data <= bus.i_rs1_data;
            bus.o_rs2_data <= bus.i_rs2_data;
            bus.o_pc       <= bus.i_pc;
        end
    end

endmodule

// File: tb/tb_decode_exec_ctrl.sv
// Directed bench for decode_exec_ctrl: branch resolution, immediates, ALU encoding,
// stall/kill priority and asynchronous reset.
module tb_decode_exec_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q[$];

    decode_exec_ctrl_if bus();

    decode_exec_ctrl #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
        bus.i_instr      = instr;
        bus.i_pc         = pc;
        bus.i_rs1_data   = rs1;
        bus.i_rs2_data   = rs2;
        bus.i_prediction = pred;
    endtask

    // One instruction: comb outputs checked before the edge, ID/EX bundle after it.
    task automatic apply_vec(input string tag,
                             input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                             input logic exp_boj, input logic [31:0] exp_bpc,
                             input logic exp_flush, input logic [31:0] exp_imm,
                             input logic [3:0] exp_alu);
        logic [31:0] e;
        @(negedge clk);
        drive(instr, pc, rs1, rs2, pred);
        #1;
        check_val({tag, ".boj"},   {31'b0, bus.o_boj},   {31'b0, exp_boj});
        check_val({tag, ".bpc"},   bus.o_branch_pc,      exp_bpc);
        check_val({tag, ".flush"}, {31'b0, bus.o_flush}, {31'b0, exp_flush});
        exp_q.push_back(exp_imm);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".imm"},    bus.o_imm,                 e);
        check_val({tag, ".alu"},    {28'b0, bus.o_alu_ctrl},   {28'b0, exp_alu});
        check_val({tag, ".opcode"}, {25'b0, bus.o_opcode},     {25'b0, instr[6:0]});
        check_val({tag, ".func3"},  {29'b0, bus.o_func3},      {29'b0, instr[14:12]});
        check_val({tag, ".rs1"},    bus.o_rs1_data,            rs1);
        check_val({tag, ".rs2"},    bus.o_rs2_data,            rs2);
        check_val({tag, ".pc"},     bus.o_pc,                  pc);
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] imm, input logic [3:0] alu,
                                input logic [6:0] opc, input logic [2:0] f3,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc);
        check_val({tag, ".imm"},    bus.o_imm,               imm);
        check_val({tag, ".alu"},    {28'b0, bus.o_alu_ctrl}, {28'b0, alu});
        check_val({tag, ".opcode"}, {25'b0, bus.o_opcode},   {25'b0, opc});
        check_val({tag, ".func3"},  {29'b0, bus.o_func3},    {29'b0, f3});
        check_val({tag, ".rs1"},    bus.o_rs1_data,          rs1);
        check_val({tag, ".rs2"},    bus.o_rs2_data,          rs2);
        check_val({tag, ".pc"},     bus.o_pc,                pc);
    endtask

    // Stimulus and checks.
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_kill  = 1'b0;
        drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset state.
        #12;
        check_bundle("reset", 32'h0, 4'h0, 7'h13, 3'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Branches.
        apply_vec("beq",  32'h0020_8463, 32'h100, 32'h5, 32'h5, 1'b0,
                  1'b1, 32'h108, 1'b1, 32'h8, 4'b1000);
        apply_vec("blt",  32'h0020_C463, 32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1,
                  1'b1, 32'h208, 1'b0, 32'h8, 4'b1000);
        apply_vec("bltu", 32'h0020_E463, 32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1,
                  1'b0, 32'h204, 1'b1, 32'h8, 4'b1000);
        apply_vec("bne",  32'h0020_9463, 32'h240, 32'h7, 32'h7, 1'b0,
                  1'b0, 32'h244, 1'b0, 32'h8, 4'b1000);
        apply_vec("b010", 32'h0020_A463, 32'h260, 32'h7, 32'h7, 1'b0,
                  1'b0, 32'h264, 1'b0, 32'h8, 4'b1000);

        // Jumps.
        apply_vec("jalr", 32'h0040_80E7, 32'h280, 32'h1003, 32'h0, 1'b0,
                  1'b1, 32'h1006, 1'b1, 32'h4, 4'b0000);
        apply_vec("jal",  32'h0100_00EF, 32'h300, 32'h0, 32'h0, 1'b1,
                  1'b1, 32'h310, 1'b0, 32'h10, 4'b0000);

        // Immediates and ALU encodings.
        apply_vec("sw",   32'hFE11_2E23, 32'h320, 32'hA, 32'hB, 1'b0,
                  1'b0, 32'h324, 1'b0, 32'hFFFF_FFFC, 4'b0000);
        apply_vec("sub",  32'h4020_81B3, 32'h324, 32'h9, 32'h3, 1'b0,
                  1'b0, 32'h328, 1'b0, 32'h0, 4'b1000);
        apply_vec("srai", 32'h4030_D193, 32'h328, 32'h80, 32'h0, 1'b0,
                  1'b0, 32'h32C, 1'b0, 32'h403, 4'b1101);
        apply_vec("lui",  32'h1234_52B7, 32'h32C, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h330, 1'b0, 32'h1234_5000, 4'b0000);
        apply_vec("addim1", 32'hFFF0_0093, 32'h330, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h334, 1'b0, 32'hFFFF_FFFF, 4'b0000);
        apply_vec("unk",  32'h0000_007F, 32'h334, 32'h1, 32'h2, 1'b1,
                  1'b0, 32'h338, 1'b1, 32'h0, 4'b0000);

        // Stall for two cycles: bundle from the SUB must stay frozen.
        apply_vec("pre_stall", 32'h4020_81B3, 32'h400, 32'h11, 32'h22, 1'b0,
                  1'b0, 32'h404, 1'b0, 32'h0, 4'b1000);
        @(negedge clk);
        bus.i_stall = 1'b1;
        drive(32'h1234_52B7, 32'h500, 32'h99, 32'h98, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_bundle("stall", 32'h0, 4'b1000, 7'h33, 3'h0, 32'h11, 32'h22, 32'h400);
        end

        // Kill while still stalled: bubble wins, PC retained.
        @(negedge clk);
        bus.i_kill = 1'b1;
        @(posedge clk);
        #1;
        check_bundle("kill", 32'h0, 4'b0000, 7'h13, 3'h0, 32'h0, 32'h0, 32'h400);
        @(negedge clk);
        bus.i_kill  = 1'b0;
        bus.i_stall = 1'b0;

        // Load something non-zero, then assert reset asynchronously between edges.
        apply_vec("pre_rst", 32'hFE11_2E23, 32'h600, 32'h5, 32'h6, 1'b0,
                  1'b0, 32'h604, 1'b0, 32'hFFFF_FFFC, 4'b0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bundle("async_rst", 32'h0, 4'h0, 7'h13, 3'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release loads normally.
        apply_vec("post_rst", 32'h0020_8463, 32'h700, 32'h1, 32'h1, 1'b1,
                  1'b1, 32'h708, 1'b0, 32'h8, 4'b1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
